barrel_pipe: RTL and testbench

Pipelined, parametrised barrel shifter with valid/ready handshaking on both sides. It supports logical shift left (lsl), logical shift right (lsr), arithmetic shift right (asr) and rotate right (ror), and can optionally report a carry flag. It sits between the processor's register-read stage and the ALU result mux, and replaces the single-cycle 16-bit shifter. Throughput is one operation per cycle, with full backpressure support.

---
 rtl/barrel_pipe.sv | 156 +++++++++++++++
 tb/tb_barrel_pipe.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/barrel_pipe.sv
// barrel_pipe: pipelined barrel shifter (lsl / lsr / asr / ror) with
// valid/ready handshaking on both sides and LOG2W register stages.
// Stage k applies a shift or rotate of 2^k when its shift bit is set.
// Optional feature: define BARREL_PIPE_CARRY_EN to add the carry_out port and
// the carry registers that travel with the data.
//
// Handshake: an input transfers on a rising edge with in_valid && in_ready,
// and an output transfers on a rising edge with out_valid && out_ready. The
// whole pipeline moves as one: adv = !out_valid || out_ready. in_ready is
// adv, so it never depends on in_valid. While adv = 0 every stage holds,
// which keeps data_out stable. Bubbles are not collapsed.
module barrel_pipe #(
    parameter int WIDTH = 16,
    parameter int LOG2W = $clog2(WIDTH)
) (
    input  logic             Clock,
    input  logic             Resetn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       shift_type,
    input  logic [LOG2W-1:0] shift,
    input  logic [WIDTH-1:0] data_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] data_out
`ifdef BARREL_PIPE_CARRY_EN
    ,
    output logic             carry_out
`endif
);

    localparam logic [1:0] T_LSL = 2'b00;
    localparam logic [1:0] T_LSR = 2'b01;
    localparam logic [1:0] T_ASR = 2'b10;

    // One partial step of 'amt' (a power of two, 1..WIDTH/2).
    function automatic logic [WIDTH-1:0] step_data(input logic [WIDTH-1:0] d,
                                                   input logic [1:0] t,
                                                   input int amt);
        logic [WIDTH-1:0] r;
        case (t)
            T_LSL:   r = d << amt;
            T_LSR:   r = d >> amt;
            T_ASR:   r = $unsigned($signed(d) >>> amt);
            default: r = (d >> amt) | (d << (WIDTH - amt));
        endcase
        return r;
    endfunction

    // The last bit leaving the word during one step. For ror, the bit that
    // wraps from the bottom to bit WIDTH-1 is the same bit lsr would drop.
    // Chaining steps leaves the carry of the last active stage, which equals
    // the carry of the full shift.
    function automatic logic step_carry(input logic [WIDTH-1:0] d,
                                        input logic [1:0] t,
                                        input int amt);
        logic c;
        if (t == T_LSL) c = d[LOG2W'(WIDTH - amt)];
        else            c = d[LOG2W'(amt - 1)];
        return c;
    endfunction

    // Stage registers. The shift amount and the type are not needed after
    // the last stage, so only LOG2W-1 copies of them are kept.
    logic             v_q [LOG2W];
    logic [WIDTH-1:0] d_q [LOG2W];
    logic [LOG2W-1:0] r_q [LOG2W-1];
    logic [1:0]       t_q [LOG2W-1];

    // Stage inputs, either from the port or from the previous stage.
    logic             v_in [LOG2W];
    logic [WIDTH-1:0] d_in [LOG2W];
    logic [LOG2W-1:0] r_in [LOG2W];
    logic [1:0]       t_in [LOG2W];
    logic [WIDTH-1:0] d_nx [LOG2W];

`ifdef BARREL_PIPE_CARRY_EN
    logic c_q  [LOG2W];
    logic c_in [LOG2W];
    logic c_nx [LOG2W];
`endif

    logic adv;

    // Global advance enable, which doubles as the input ready.
    always_comb begin
        adv      = !out_valid || out_ready;
        in_ready = adv;
    end

    // Stage input selection and per-stage shift. The shift amount moves down
    // one bit per stage, so bit 0 always selects the current stage.
    always_comb begin
        v_in[0] = in_valid && in_ready;
        d_in[0] = data_in;
        r_in[0] = shift;
        t_in[0] = shift_type;
`ifdef BARREL_PIPE_CARRY_EN
        c_in[0] = 1'b0;
`endif
        for (int k = 1; k < LOG2W; k++) begin
            v_in[k] = v_q[k-1];
            d_in[k] = d_q[k-1];
            r_in[k] = r_q[k-1];
            t_in[k] = t_q[k-1];
`ifdef BARREL_PIPE_CARRY_EN
            c_in[k] = c_q[k-1];
`endif
        end
        for (int k = 0; k < LOG2W; k++) begin
            d_nx[k] = r_in[k][0] ? step_data(d_in[k], t_in[k], 1 << k) : d_in[k];
`ifdef BARREL_PIPE_CARRY_EN
            c_nx[k] = r_in[k][0] ? step_carry(d_in[k], t_in[k], 1 << k) : c_in[k];
`endif
        end
    end

    // Pipeline registers: clear on reset, load together when adv is high.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            for (int k = 0; k < LOG2W; k++) begin
                v_q[k] <= 1'b0;
                d_q[k] <= '0;
`ifdef BARREL_PIPE_CARRY_EN
                c_q[k] <= 1'b0;
`endif
            end
            for (int k = 0; k < LOG2W - 1; k++) begin
                r_q[k] <= '0;
                t_q[k] <= '0;
            end
        end else if (adv) begin
            for (int k = 0; k < LOG2W; k++) begin
                v_q[k] <= v_in[k];
                d_q[k] <= d_nx[k];
`ifdef BARREL_PIPE_CARRY_EN
                c_q[k] <= c_nx[k];
`endif
            end
            for (int k = 0; k < LOG2W - 1; k++) begin
                r_q[k] <= r_in[k] >> 1;
                t_q[k] <= t_in[k];
            end
        end
    end

    // The last stage drives the outputs directly.
    always_comb begin
        out_valid = v_q[LOG2W-1];
        data_out  = d_q[LOG2W-1];
`ifdef BARREL_PIPE_CARRY_EN
        carry_out = c_q[LOG2W-1];
`endif
    end

endmodule

// File: tb/tb_barrel_pipe.sv
// tb_barrel_pipe: bench for barrel_pipe (WIDTH = 16 main instance, plus a
// WIDTH = 32 instance for the generic check). Carry checks are active when
// BARREL_PIPE_CARRY_EN is defined.
module tb_barrel_pipe;

    logic        Clock;
    logic        Resetn;

    logic        in_valid;
    logic        in_ready;
    logic [1:0]  shift_type;
    logic [3:0]  shift;
    logic [15:0] data_in;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] data_out;
    logic        carry_out;

    logic        v32;
    logic        rdy32;
    logic [1:0]  t32;
    logic [4:0]  s32;
    logic [31:0] d32;
    logic        ov32;
    logic        ord32;
    logic [31:0] do32;
    logic        c32;

    int checks;
    int passed;

    logic [16:0] exp_q[$];
    logic        stall_prev;
    logic [15:0] prev_data;
    logic [16:0] e;

    // ---------------- clock / reset ----------------
    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    barrel_pipe #(.WIDTH(16)) dut16 (
        .Clock     (Clock),
        .Resetn    (Resetn),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .shift_type(shift_type),
        .shift     (shift),
        .data_in   (data_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .data_out  (data_out)
`ifdef BARREL_PIPE_CARRY_EN
        ,
        .carry_out (carry_out)
`endif
    );

    barrel_pipe #(.WIDTH(32)) dut32 (
        .Clock     (Clock),
        .Resetn    (Resetn),
        .in_valid  (v32),
        .in_ready  (rdy32),
        .shift_type(t32),
        .shift     (s32),
        .data_in   (d32),
        .out_valid (ov32),
        .out_ready (ord32),
        .data_out  (do32)
`ifdef BARREL_PIPE_CARRY_EN
        ,
        .carry_out (c32)
`endif
    );

`ifndef BARREL_PIPE_CARRY_EN
    assign carry_out = 1'b0;
    assign c32       = 1'b0;
`endif

    // ---------------- check helper ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    // ---------------- reference model ----------------
    // Whole-shift arithmetic straight from the shift rules; returns {carry, data}.
    function automatic logic [16:0] model(input logic [15:0] d, input logic [1:0] t,
                                          input logic [3:0] s);
        int          n;
        logic [15:0] r;
        logic [15:0] ones;
        logic        c;
        n    = int'(s);
        ones = 16'hFFFF;
        if (n == 0) return {1'b0, d};
        case (t)
            2'b00: begin r = d << n; c = d[16 - n]; end
            2'b01: begin r = d >> n; c = d[n - 1]; end
            2'b10: begin r = (d >> n) | (d[15] ? ~(ones >> n) : 16'h0000); c = d[n - 1]; end
            default: begin r = (d >> n) | (d << (16 - n)); c = r[15]; end
        endcase
        return {c, r};
    endfunction

    // ---------------- scoreboard / compare process ----------------
    always @(negedge Clock) begin
        if (!Resetn) begin
            exp_q.delete();
            stall_prev = 1'b0;
        end else begin
            check("in_ready_rule", in_ready, !out_valid || out_ready);
            if (stall_prev) begin
                check("stall_valid", out_valid, 1);
                check("stall_data", data_out, prev_data);
            end
            if (out_valid && out_ready) begin
                check("result_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("sb_data", data_out, e[15:0]);
`ifdef BARREL_PIPE_CARRY_EN
                    check("sb_carry", carry_out, e[16]);
`endif
                end
            end
            if (in_valid && in_ready) exp_q.push_back(model(data_in, shift_type, shift));
            stall_prev = out_valid && !out_ready;
            prev_data  = data_out;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic single(input string name, input logic [1:0] t, input logic [3:0] s,
                          input logic [15:0] d, input logic [15:0] exp_d, input logic exp_c);
        @(posedge Clock); #1;
        in_valid = 1'b1; shift_type = t; shift = s; data_in = d; out_ready = 1'b1;
        @(posedge Clock); #1;
        in_valid = 1'b0;
        repeat (3) begin
            @(negedge Clock);
            check({name, "_early"}, out_valid, 0);
        end
        @(negedge Clock);
        check({name, "_valid"}, out_valid, 1);
        check({name, "_data"}, data_out, exp_d);
`ifdef BARREL_PIPE_CARRY_EN
        check({name, "_carry"}, carry_out, exp_c);
`else
        if (exp_c === 1'bx) $display("note: bad carry literal in %s", name);
`endif
    endtask

    task automatic drain(input string name);
        int k;
        out_ready = 1'b1;
        in_valid  = 1'b0;
        k = 0;
        while (exp_q.size() != 0 && k < 50) begin
            @(negedge Clock);
            k++;
        end
        check({name, "_drained"}, exp_q.size(), 0);
    endtask

    task automatic streaming();
        int cnt, first, last;
        cnt = 0; first = -1; last = -1;
        for (int j = 0; j < 40; j++) begin
            @(posedge Clock); #1;
            out_ready  = 1'b1;
            in_valid   = (j < 32);
            shift_type = 2'($urandom_range(0, 3));
            shift      = 4'($urandom_range(0, 15));
            data_in    = 16'($urandom_range(0, 65535));
            @(negedge Clock);
            if (out_valid) begin
                cnt++;
                if (first < 0) first = j;
                last = j;
            end
        end
        check("stream_count", cnt, 32);
        check("stream_first", first, 4);
        check("stream_last", last, 35);
    endtask

    task automatic backpressure();
        int sent, iter;
        sent = 0; iter = 0;
        while (sent < 32 && iter < 2000) begin
            @(posedge Clock); #1;
            in_valid   = 1'($urandom_range(0, 1));
            out_ready  = 1'($urandom_range(0, 1));
            shift_type = 2'($urandom_range(0, 3));
            shift      = 4'($urandom_range(0, 15));
            data_in    = 16'($urandom_range(0, 65535));
            @(negedge Clock);
            if (in_valid && in_ready) sent++;
            iter++;
        end
        check("bp_sent", sent, 32);
        @(posedge Clock); #1;
        drain("bp");
    endtask

    task automatic reset_midflight();
        for (int j = 0; j < 3; j++) begin
            @(posedge Clock); #1;
            in_valid = 1'b1; out_ready = 1'b1;
            shift_type = 2'b00; shift = 4'd0; data_in = 16'h00FF + 16'(j);
        end
        @(posedge Clock); #1;
        in_valid = 1'b0;
        @(posedge Clock); #1;
        check("pre_reset_valid", out_valid, 1);
        #1;
        Resetn = 1'b0;
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_data_out", data_out, 16'h0000);
        check("rst_in_ready", in_ready, 1);
`ifdef BARREL_PIPE_CARRY_EN
        check("rst_carry", carry_out, 0);
`endif
        @(negedge Clock);
        @(posedge Clock); #1;
        Resetn = 1'b1;
        for (int j = 0; j < 8; j++) begin
            @(negedge Clock);
            check("post_rst_quiet", out_valid, 0);
        end
    endtask

    task automatic wide_asr();
        @(posedge Clock); #1;
        v32 = 1'b1; t32 = 2'b10; s32 = 5'd31; d32 = 32'h8000_0000;
        @(posedge Clock); #1;
        v32 = 1'b0;
        repeat (4) begin
            @(negedge Clock);
            check("w32_early", ov32, 0);
        end
        @(negedge Clock);
        check("w32_valid", ov32, 1);
        check("w32_data", do32, 32'hFFFF_FFFF);
`ifdef BARREL_PIPE_CARRY_EN
        check("w32_carry", c32, 0);
`endif
    endtask

    // ---------------- main sequence ----------------
    initial begin
        checks = 0; passed = 0;
        stall_prev = 1'b0; prev_data = '0;
        Resetn = 1'b0;
        in_valid = 1'b0; shift_type = 2'b00; shift = '0; data_in = '0; out_ready = 1'b0;
        v32 = 1'b0; t32 = 2'b00; s32 = '0; d32 = '0; ord32 = 1'b1;

        repeat (3) @(negedge Clock);
        check("reset_out_valid", out_valid, 0);
        check("reset_data_out", data_out, 16'h0000);
        check("reset_in_ready", in_ready, 1);
`ifdef BARREL_PIPE_CARRY_EN
        check("reset_carry", carry_out, 0);
`endif
        @(posedge Clock); #1;
        Resetn = 1'b1;

        single("lsl", 2'b00, 4'd1, 16'h8001, 16'h0002, 1'b1);
        single("lsr", 2'b01, 4'd5, 16'h00F0, 16'h0007, 1'b1);
        single("asr", 2'b10, 4'd4, 16'h8000, 16'hF800, 1'b0);
        single("ror", 2'b11, 4'd4, 16'h1234, 16'h4123, 1'b0);
        for (int t = 0; t < 4; t++)
            single("zero", 2'(t), 4'd0, 16'hA5A5, 16'hA5A5, 1'b0);
        single("ror15", 2'b11, 4'd15, 16'h0001, 16'h0002, 1'b0);

        streaming();
        drain("stream");
        backpressure();
        reset_midflight();
        wide_asr();

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d passed=%0d", checks, passed);
        $fatal(1);
    end

endmodule
